iic_eeprom_slave: RTL and testbench

I2C target (responder) that emulates a 24Cxx-style EEPROM on the board-level I2C bus. It answers the device address and address/data sequences issued by the I2C master that loads calibration parameters (device ID 0xA0, byte-addressed, sequential read of up to 192 bytes). It holds its own byte memory, so the calibration-load path can run end-to-end in simulation and on boards without a fitted EEPROM. It sits directly on the iic_clk/iic_sda pins in place of the physical device.

---
 rtl/iic_pkg.sv | 24 ++
 rtl/iic_slave_ram.sv | 23 ++
 rtl/iic_eeprom_slave.sv | 271 +++++++++++++++++++++++++++
 tb/tb_iic_eeprom_slave.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iic_pkg.sv
// Shared I2C definitions: device ID, ACK/NACK levels and target FSM states.
// IIC_SLV_ADDR16_EN adds the high-address-byte state.
package iic_pkg;

  localparam logic [7:0] IIC_DEV_ID = 8'hA0;
  localparam logic       IIC_ACK    = 1'b0;
  localparam logic       IIC_NACK   = 1'b1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_DEV,
    S_DEV_ACK,
`ifdef IIC_SLV_ADDR16_EN
    S_ADDR_H,
`endif
    S_ADDR_L,
    S_ADDR_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RDATA_ACK
  } iic_state_e;

endpackage

// File: rtl/iic_slave_ram.sv
// Byte RAM for the EEPROM emulator: synchronous write, registered read.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read). No reset.
module iic_slave_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/iic_eeprom_slave.sv
// I2C target emulating a 24Cxx EEPROM (ID DEV_ID, byte memory of DEPTH).
// Ports: clk, rst_n, iic_clk (SCL), iic_sda (open-drain SDA), busy,
// wr_evt/wr_addr/wr_byte (write strobe). Macro: IIC_SLV_ADDR16_EN.
module iic_eeprom_slave
  import iic_pkg::*;
#(
  parameter logic [7:0] DEV_ID = IIC_DEV_ID,
  parameter int         DEPTH  = 256,
  parameter int         AW     = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          iic_clk,
  inout  wire           iic_sda,
  output logic          busy,
  output logic          wr_evt,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_byte
);

  logic [2:0] scl_q;
  logic [2:0] sda_q;
  logic       scl, scl_d, sda, sda_d;
  logic       scl_rise, scl_fall;
  logic       start, stop;

  iic_state_e    state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic [7:0]    shreg, sh_nxt;
  logic [7:0]    byte_in;
  logic [AW-1:0] ptr, ptr_nxt;
  logic          sda_oe, oe_nxt;
  logic          rw, rw_nxt;
  logic          busy_nxt;
  logic          wr_evt_nxt;
  logic [AW-1:0] wr_addr_nxt;
  logic [7:0]    wr_byte_nxt;
  logic [7:0]    rd_data;
`ifdef IIC_SLV_ADDR16_EN
  logic [7:0]    addr_hi, ahi_nxt;
  logic          hi_pend, hi_nxt;
`endif

  assign scl   = scl_q[1];
  assign scl_d = scl_q[2];
  assign sda   = sda_q[1];
  assign sda_d = sda_q[2];

  assign scl_rise = scl & ~scl_d;
  assign scl_fall = ~scl & scl_d;
  assign start    = scl & scl_d & sda_d & ~sda;
  assign stop     = scl & scl_d & ~sda_d & sda;

  assign iic_sda = sda_oe ? 1'b0 : 1'bz;
  assign byte_in = {shreg[6:0], sda};

  iic_slave_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_evt),
    .waddr (wr_addr),
    .wdata (wr_byte),
    .raddr (ptr),
    .rdata (rd_data)
  );

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    sh_nxt      = shreg;
    ptr_nxt     = ptr;
    oe_nxt      = sda_oe;
    rw_nxt      = rw;
    busy_nxt    = busy;
    wr_evt_nxt  = 1'b0;
    wr_addr_nxt = wr_addr;
    wr_byte_nxt = wr_byte;
`ifdef IIC_SLV_ADDR16_EN
    ahi_nxt     = addr_hi;
    hi_nxt      = hi_pend;
`endif
    if (start) begin
      state_nxt = S_DEV;
      cnt_nxt   = 4'd0;
      oe_nxt    = 1'b0;
    end else if (stop) begin
      state_nxt = S_IDLE;
      oe_nxt    = 1'b0;
      busy_nxt  = 1'b0;
    end else begin
      unique case (state)
        S_IDLE: ;
        S_DEV: begin
          if (scl_rise) begin
            sh_nxt  = byte_in;
            cnt_nxt = cnt + 4'd1;
          end
          if (scl_fall && cnt == 4'd8) begin
            cnt_nxt = 4'd0;
            if (shreg[7:1] == DEV_ID[7:1]) begin
              state_nxt = S_DEV_ACK;
              oe_nxt    = 1'b1;
              busy_nxt  = 1'b1;
              rw_nxt    = shreg[0];
            end else begin
              state_nxt = S_IDLE;
              busy_nxt  = 1'b0;
            end
          end
        end
        S_DEV_ACK: begin
          if (scl_rise && rw)
            sh_nxt = rd_data;
          if (scl_fall) begin
            cnt_nxt = 4'd0;
            if (rw) begin
              state_nxt = S_RDATA;
              oe_nxt    = ~shreg[7];
            end else begin
              oe_nxt    = 1'b0;
`ifdef IIC_SLV_ADDR16_EN
              state_nxt = S_ADDR_H;
`else
              state_nxt = S_ADDR_L;
`endif
            end
          end
        end
`ifdef IIC_SLV_ADDR16_EN
        S_ADDR_H: begin
          if (scl_rise) begin
            sh_nxt  = byte_in;
            cnt_nxt = cnt + 4'd1;
          end
          if (scl_fall && cnt == 4'd8) begin
            ahi_nxt   = shreg;
            hi_nxt    = 1'b1;
            state_nxt = S_ADDR_ACK;
            oe_nxt    = 1'b1;
            cnt_nxt   = 4'd0;
          end
        end
`endif
        S_ADDR_L: begin
          if (scl_rise) begin
            sh_nxt  = byte_in;
            cnt_nxt = cnt + 4'd1;
          end
          if (scl_fall && cnt == 4'd8) begin
`ifdef IIC_SLV_ADDR16_EN
            ptr_nxt = AW'({addr_hi, shreg});
`else
            ptr_nxt = AW'(shreg);
`endif
            state_nxt = S_ADDR_ACK;
            oe_nxt    = 1'b1;
            cnt_nxt   = 4'd0;
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            oe_nxt    = 1'b0;
            cnt_nxt   = 4'd0;
            state_nxt = S_WDATA;
`ifdef IIC_SLV_ADDR16_EN
            if (hi_pend) begin
              state_nxt = S_ADDR_L;
              hi_nxt    = 1'b0;
            end
`endif
          end
        end
        S_WDATA: begin
          if (scl_rise) begin
            sh_nxt  = byte_in;
            cnt_nxt = cnt + 4'd1;
            if (cnt == 4'd7) begin
              wr_evt_nxt  = 1'b1;
              wr_addr_nxt = ptr;
              wr_byte_nxt = byte_in;
              ptr_nxt     = ptr + AW'(1);
            end
          end
          if (scl_fall && cnt == 4'd8) begin
            state_nxt = S_WDATA_ACK;
            oe_nxt    = 1'b1;
            cnt_nxt   = 4'd0;
          end
        end
        S_WDATA_ACK: begin
          if (scl_fall) begin
            oe_nxt    = 1'b0;
            state_nxt = S_WDATA;
          end
        end
        S_RDATA: begin
          if (scl_rise)
            cnt_nxt = cnt + 4'd1;
          if (scl_fall) begin
            if (cnt == 4'd8) begin
              oe_nxt    = 1'b0;
              ptr_nxt   = ptr + AW'(1);
              state_nxt = S_RDATA_ACK;
              cnt_nxt   = 4'd0;
            end else begin
              oe_nxt = ~shreg[6];
              sh_nxt = {shreg[6:0], 1'b0};
            end
          end
        end
        S_RDATA_ACK: begin
          if (scl_rise) begin
            if (sda == IIC_NACK) begin
              state_nxt = S_IDLE;
              busy_nxt  = 1'b0;
            end else begin
              sh_nxt = rd_data;
            end
          end
          if (scl_fall) begin
            state_nxt = S_RDATA;
            oe_nxt    = ~shreg[7];
            cnt_nxt   = 4'd0;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q   <= 3'b111;
      sda_q   <= 3'b111;
      state   <= S_IDLE;
      cnt     <= 4'd0;
      shreg   <= 8'd0;
      ptr     <= '0;
      sda_oe  <= 1'b0;
      rw      <= 1'b0;
      busy    <= 1'b0;
      wr_evt  <= 1'b0;
      wr_addr <= '0;
      wr_byte <= 8'd0;
`ifdef IIC_SLV_ADDR16_EN
      addr_hi <= 8'd0;
      hi_pend <= 1'b0;
`endif
    end else begin
      scl_q   <= {scl_q[1:0], iic_clk};
      sda_q   <= {sda_q[1:0], iic_sda};
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      shreg   <= sh_nxt;
      ptr     <= ptr_nxt;
      sda_oe  <= oe_nxt;
      rw      <= rw_nxt;
      busy    <= busy_nxt;
      wr_evt  <= wr_evt_nxt;
      wr_addr <= wr_addr_nxt;
      wr_byte <= wr_byte_nxt;
`ifdef IIC_SLV_ADDR16_EN
      addr_hi <= ahi_nxt;
      hi_pend <= hi_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_iic_eeprom_slave.sv
// Bench for iic_eeprom_slave: bit-banged I2C master with a
// write/read scoreboard and a byte-memory model.
module tb_iic_eeprom_slave;
  import iic_pkg::*;

  localparam int Q = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  wire        sda;
  logic       busy, wr_evt;
  logic [7:0] wr_addr, wr_byte;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem_m [256];
  logic        known [256];
  logic [7:0]  ptr_m = 8'd0;
  logic [15:0] wq[$];
  logic [8:0]  rq[$];

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  iic_eeprom_slave dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .iic_clk (scl),
    .iic_sda (sda),
    .busy    (busy),
    .wr_evt  (wr_evt),
    .wr_addr (wr_addr),
    .wr_byte (wr_byte)
  );

  always @(negedge clk) begin
    if (rst_n && wr_evt) begin
      checks++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL wr_evt_unexpected addr %h byte %h",
                 wr_addr, wr_byte);
      end else begin
        logic [15:0] e;
        e = wq.pop_front();
        if ({wr_addr, wr_byte} !== e) begin
          errors++;
          $display("FAIL wr_evt got %h/%h expected %h/%h",
                   wr_addr, wr_byte, e[15:8], e[7:0]);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_out(input logic b);
    tick(Q); m_low = ~b;
    tick(Q); scl = 1'b1;
    tick(2*Q); scl = 1'b0;
  endtask

  task automatic bit_in(output logic b);
    tick(Q); m_low = 1'b0;
    tick(Q); scl = 1'b1;
    tick(Q); b = sda;
    tick(Q); scl = 1'b0;
  endtask

  task automatic start_c();
    m_low = 1'b0;
    tick(Q); scl = 1'b1;
    tick(Q); m_low = 1'b1;
    tick(Q); scl = 1'b0;
  endtask

  task automatic stop_c();
    m_low = 1'b1;
    tick(Q); scl = 1'b1;
    tick(Q); m_low = 1'b0;
    tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack,
                           input string name);
    logic a;
    for (int i = 7; i >= 0; i--) bit_out(b[i]);
    bit_in(a);
    checks++;
    if (a !== exp_ack) begin
      errors++;
      $display("FAIL %s ack got %b expected %b", name, a, exp_ack);
    end
  endtask

  task automatic send_addr(input logic [7:0] a);
`ifdef IIC_SLV_ADDR16_EN
    send_byte(8'h00, IIC_ACK, "addr_h");
`endif
    send_byte(a, IIC_ACK, "addr_l");
    ptr_m = a;
  endtask

  task automatic wr_data(input logic [7:0] b);
    wq.push_back({ptr_m, b});
    mem_m[ptr_m] = b;
    known[ptr_m] = 1'b1;
    ptr_m++;
    send_byte(b, IIC_ACK, "wdata");
  endtask

  task automatic read_bytes(input int n, input string name);
    logic [8:0] e;
    logic [7:0] got;
    logic       b;
    for (int k = 0; k < n; k++) begin
      rq.push_back({known[ptr_m], mem_m[ptr_m]});
      ptr_m++;
      for (int i = 7; i >= 0; i--) begin
        bit_in(b);
        got[i] = b;
      end
      bit_out(k == n - 1 ? IIC_NACK : IIC_ACK);
      e = rq.pop_front();
      if (e[8]) begin
        checks++;
        if (got !== e[7:0]) begin
          errors++;
          $display("FAIL %s[%0d] got %h expected %h",
                   name, k, got, e[7:0]);
        end
      end
    end
  endtask

  task automatic check_bit(input logic got, input logic exp,
                           input string name);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b", name, got, exp);
    end
  endtask

  task automatic check_wq_empty(input string name);
    checks++;
    if (wq.size() != 0) begin
      errors++;
      $display("FAIL %s pending writes %0d expected 0",
               name, wq.size());
      wq.delete();
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, wr_evt, wr_addr, wr_byte, sda} !== {18'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset got b%b e%b a%h d%h sda%b expected 0 0 00 00 1",
               busy, wr_evt, wr_addr, wr_byte, sda);
    end
  endtask

  task automatic test_byte_write();
    start_c();
    send_byte(8'hA0, IIC_ACK, "bw_dev");
    send_addr(8'h05);
    wr_data(8'h3C);
    check_bit(busy, 1'b1, "bw_busy_on");
    stop_c();
    tick(10);
    check_bit(busy, 1'b0, "bw_busy_off");
    check_wq_empty("bw_wq");
  endtask

  task automatic test_random_read();
    start_c();
    send_byte(8'hA0, IIC_ACK, "rr_dev_w");
    send_addr(8'h05);
    start_c();
    send_byte(8'hA1, IIC_ACK, "rr_dev_r");
    read_bytes(1, "rr_data");
    tick(2);
    check_bit(sda, 1'b1, "rr_sda_released");
    check_bit(busy, 1'b0, "rr_busy_nack");
    stop_c();
  endtask

  task automatic test_reset_mid_read();
    start_c();
    send_byte(8'hA0, IIC_ACK, "mr_dev_w");
    send_addr(8'h05);
    start_c();
    send_byte(8'hA1, IIC_ACK, "mr_dev_r");
    tick(Q);
    check_bit(sda, 1'b0, "mr_msb_driven");
    rst_n = 1'b0;
    tick(1);
    check_bit(sda, 1'b1, "mr_sda_after_rst");
    tick(3);
    rst_n = 1'b1;
    tick(3);
    stop_c();
    tick(5);
    check_bit(busy, 1'b0, "mr_busy");
    start_c();
    send_byte(8'hA0, IIC_ACK, "mr2_dev_w");
    send_addr(8'h05);
    start_c();
    send_byte(8'hA1, IIC_ACK, "mr2_dev_r");
    read_bytes(1, "mr2_data");
    stop_c();
  endtask

  task automatic test_id_mismatch();
    logic b;
    logic all_hi;
    start_c();
    send_byte(8'hA2, IIC_NACK, "id_mismatch");
    all_hi = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bit_in(b);
      all_hi &= b;
    end
    check_bit(all_hi, 1'b1, "id_sda_stays_z");
    check_bit(busy, 1'b0, "id_busy");
    stop_c();
  endtask

  task automatic test_abort_stop();
    start_c();
    send_byte(8'hA0, IIC_ACK, "ab_dev");
    send_addr(8'h10);
    for (int i = 0; i < 4; i++) bit_out(i[0]);
    stop_c();
    tick(10);
    check_bit(busy, 1'b0, "ab_busy");
    check_wq_empty("ab_wq");
  endtask

  task automatic test_seq_wrap();
    start_c();
    send_byte(8'hA0, IIC_ACK, "sq_pre_dev");
    send_addr(8'h01);
    for (int i = 0; i < 10; i++) wr_data(8'(8'h40 + i * 7));
    stop_c();
    start_c();
    send_byte(8'hA0, IIC_ACK, "sq_dev");
    send_addr(8'hFE);
    wr_data(8'h11);
    wr_data(8'h22);
    wr_data(8'h33);
    stop_c();
    tick(5);
    check_wq_empty("sq_wq");
    start_c();
    send_byte(8'hA0, IIC_ACK, "sq_rd_dev_w");
    send_addr(8'hFE);
    start_c();
    send_byte(8'hA1, IIC_ACK, "sq_rd_dev_r");
    read_bytes(192, "sq_data");
    stop_c();
    tick(5);
    check_bit(busy, 1'b0, "sq_busy");
  endtask

`ifdef IIC_SLV_ADDR16_EN
  task automatic test_addr16();
    start_c();
    send_byte(8'hA0, IIC_ACK, "a16_dev");
    send_addr(8'h07);
    wr_data(8'h5A);
    stop_c();
    tick(10);
    check_wq_empty("a16_wq");
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) known[i] = 1'b0;
    tick(5);
    rst_n = 1'b1;
    tick(5);
    test_reset();
    test_byte_write();
    test_random_read();
    test_reset_mid_read();
    test_id_mismatch();
    test_abort_stop();
    test_seq_wrap();
`ifdef IIC_SLV_ADDR16_EN
    test_addr16();
`endif
    tick(20);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
